// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: two-requester, round-robin read arbiter that serves one
// outstanding word read at a time from a fixed-latency memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid/addr      read requests (0 = instruction fetch, 1 = data load)
//   req{0,1}_ready           request accepted this cycle
//   rsp{0,1}_valid/ready     response handshake per requester
//   rsp{0,1}_data/err        read word / request rejected (misaligned or out of range)
//   mem_en, mem_addr         read enable and byte address to the memory
//   mem_rdata                memory read data, valid MEM_LAT cycles after first mem_en
//   busy                     FSM is not in IDLE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate and accept one request
// ISSUE | first mem_en cycle, load the latency down-counter
// WAIT  | MEM_LAT cycles of mem_en; capture mem_rdata on terminal count
// RESP  | hold response for the latched requester until rsp_ready
module mem_rd_arbiter #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [31:0]           rsp0_data,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [31:0]           rsp1_data,
    output logic                  rsp1_err,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_DEPTH - 4);

    state_t                  state_q, state_d;
    logic                    last_grant_q;
    logic                    id_q;
    logic                    cooldown_q;
    logic [2:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             rsp_data_q;
    logic                    rsp_err_q;

    logic                    grant_id;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    addr_ok;

    // With both requesters valid, the one not granted last time wins.
    assign grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign sel_addr = grant_id ? req1_addr : req0_addr;
    assign addr_ok  = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);

    // One dead IDLE cycle follows every RESP before a new accept.
    assign accept   = (state_q == IDLE) && !cooldown_q && !rst && (req0_valid || req1_valid);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = addr_ok ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                mem_en  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                mem_en = 1'b1;
                if (cnt_q == 3'd0) state_d = RESP;
            end
            RESP: begin
                if (id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cooldown_q   <= 1'b0;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            rsp_data_q   <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            cooldown_q <= (state_q == RESP) && (state_d == IDLE);
            if (accept) begin
                last_grant_q <= grant_id;
                id_q         <= grant_id;
                if (addr_ok) begin
                    addr_q <= sel_addr;
                end else begin
                    rsp_data_q <= 32'd0;
                    rsp_err_q  <= 1'b1;
                end
            end
            if (state_q == ISSUE) cnt_q <= 3'(MEM_LAT - 1);
            if (state_q == WAIT) begin
                if (cnt_q == 3'd0) begin
                    rsp_data_q <= mem_rdata;
                    rsp_err_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
            end
        end
    end

    assign mem_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign rsp0_valid = (state_q == RESP) && !id_q;
    assign rsp1_valid = (state_q == RESP) && id_q;
    assign rsp0_data  = id_q ? 32'd0 : rsp_data_q;
    assign rsp1_data  = id_q ? rsp_data_q : 32'd0;
    assign rsp0_err   = !id_q && rsp_err_q;
    assign rsp1_err   = id_q && rsp_err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: one DUT per MEM_LAT value 1..4, each with
// its own latency-matched memory model; tests drive one DUT at a time.
module tb_mem_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid [1:4];
    logic [31:0] req0_addr  [1:4];
    logic        req0_ready [1:4];
    logic        req1_valid [1:4];
    logic [31:0] req1_addr  [1:4];
    logic        req1_ready [1:4];
    logic        rsp0_valid [1:4];
    logic        rsp0_ready [1:4];
    logic [31:0] rsp0_data  [1:4];
    logic        rsp0_err   [1:4];
    logic        rsp1_valid [1:4];
    logic        rsp1_ready [1:4];
    logic [31:0] rsp1_data  [1:4];
    logic        rsp1_err   [1:4];
    logic        mem_en     [1:4];
    logic [31:0] mem_addr   [1:4];
    logic        busy       [1:4];

    int n_vec  = 0;
    int n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        logic [31:0] pipe [0:3];
        logic [31:0] rdata;

        always @(posedge clk) begin
            pipe[0] <= mem_en[g] ? (32'hA500_0000 | mem_addr[g]) : 32'hDEAD_BEEF;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata = pipe[g-1];

        mem_rd_arbiter #(.MEM_DEPTH(256), .ADDR_WIDTH(32), .MEM_LAT(g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid[g]),
            .req0_addr  (req0_addr[g]),
            .req0_ready (req0_ready[g]),
            .req1_valid (req1_valid[g]),
            .req1_addr  (req1_addr[g]),
            .req1_ready (req1_ready[g]),
            .rsp0_valid (rsp0_valid[g]),
            .rsp0_ready (rsp0_ready[g]),
            .rsp0_data  (rsp0_data[g]),
            .rsp0_err   (rsp0_err[g]),
            .rsp1_valid (rsp1_valid[g]),
            .rsp1_ready (rsp1_ready[g]),
            .rsp1_data  (rsp1_data[g]),
            .rsp1_err   (rsp1_err[g]),
            .mem_en     (mem_en[g]),
            .mem_addr   (mem_addr[g]),
            .mem_rdata  (rdata),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Complete read on DUT d (MEM_LAT = d) with both rsp_ready high.
    task automatic run_read(input int d, input int id, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        rsp0_ready[d] = 1'b1;
        rsp1_ready[d] = 1'b1;
        if (id == 0) begin req0_valid[d] = 1'b1; req0_addr[d] = addr; end
        else         begin req1_valid[d] = 1'b1; req1_addr[d] = addr; end
        #1;
        chk("accept_ready", 32'(id == 0 ? req0_ready[d] : req1_ready[d]), 32'd1);
        chk("accept_other", 32'(id == 0 ? req1_ready[d] : req0_ready[d]), 32'd0);
        chk("accept_mem_en", 32'(mem_en[d]), 32'd0);
        step();
        req0_valid[d] = 1'b0;
        req1_valid[d] = 1'b0;
        if (!exp_err) begin
            for (int k = 0; k <= d; k++) begin
                #1;
                chk("rd_mem_en", 32'(mem_en[d]), 32'd1);
                chk("rd_mem_addr", mem_addr[d], addr);
                chk("rd_early_rsp", 32'(id == 0 ? rsp0_valid[d] : rsp1_valid[d]), 32'd0);
                step();
            end
        end
        #1;
        chk("rsp_valid", 32'(id == 0 ? rsp0_valid[d] : rsp1_valid[d]), 32'd1);
        chk("rsp_other_valid", 32'(id == 0 ? rsp1_valid[d] : rsp0_valid[d]), 32'd0);
        chk("rsp_data", id == 0 ? rsp0_data[d] : rsp1_data[d], exp_data);
        chk("rsp_err", 32'(id == 0 ? rsp0_err[d] : rsp1_err[d]), 32'(exp_err));
        chk("rsp_mem_en", 32'(mem_en[d]), 32'd0);
        step();
        #1;
        chk("post_rsp_valid", 32'(id == 0 ? rsp0_valid[d] : rsp1_valid[d]), 32'd0);
        chk("post_busy", 32'(busy[d]), 32'd0);
        step();
    endtask

    initial begin
        int gr_id [3];
        int gr_cyc[3];
        int ngr, n_r0, n_r1;

        rst = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            req0_valid[d] = 1'b0; req0_addr[d] = 32'd0;
            req1_valid[d] = 1'b0; req1_addr[d] = 32'd0;
            rsp0_ready[d] = 1'b0; rsp1_ready[d] = 1'b0;
        end
        @(negedge clk);

        // Reset: ready suppressed during rst, outputs zero afterwards.
        req0_valid[1] = 1'b1;
        step();
        #1;
        chk("rst_ready", 32'(req0_ready[1]), 32'd0);
        step();
        req0_valid[1] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mem_en", 32'(mem_en[1]), 32'd0);
        chk("rst_mem_addr", mem_addr[1], 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid[1]), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid[1]), 32'd0);
        chk("rst_busy", 32'(busy[1]), 32'd0);
        step();

        // Contention after reset: grants 0,1,0 spaced MEM_LAT+4 = 5 cycles.
        for (int i = 0; i < 3; i++) begin gr_id[i] = -1; gr_cyc[i] = -1; end
        ngr = 0; n_r0 = 0; n_r1 = 0;
        req0_valid[1] = 1'b1; req0_addr[1] = 32'h04;
        req1_valid[1] = 1'b1; req1_addr[1] = 32'h08;
        rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("cont_one_ready", 32'(req0_ready[1] & req1_ready[1]), 32'd0);
            chk("cont_one_rsp", 32'(rsp0_valid[1] & rsp1_valid[1]), 32'd0);
            if (ngr < 3 && req0_ready[1]) begin gr_id[ngr] = 0; gr_cyc[ngr] = c; ngr++; end
            else if (ngr < 3 && req1_ready[1]) begin gr_id[ngr] = 1; gr_cyc[ngr] = c; ngr++; end
            if (rsp0_valid[1]) begin n_r0++; chk("cont_rsp0_data", rsp0_data[1], 32'hA500_0004); end
            if (rsp1_valid[1]) begin n_r1++; chk("cont_rsp1_data", rsp1_data[1], 32'hA500_0008); end
            step();
            if (ngr == 3) begin req0_valid[1] = 1'b0; req1_valid[1] = 1'b0; end
        end
        chk("cont_ngrants", 32'(ngr), 32'd3);
        chk("cont_grant0", 32'(gr_id[0]), 32'd0);
        chk("cont_grant1", 32'(gr_id[1]), 32'd1);
        chk("cont_grant2", 32'(gr_id[2]), 32'd0);
        chk("cont_space01", 32'(gr_cyc[1] - gr_cyc[0]), 32'd5);
        chk("cont_space12", 32'(gr_cyc[2] - gr_cyc[1]), 32'd5);
        chk("cont_n_rsp0", 32'(n_r0), 32'd2);
        chk("cont_n_rsp1", 32'(n_r1), 32'd1);

        // Single read, then illegal / boundary addresses on requester 1.
        run_read(1, 0, 32'h10,  32'hA500_0010, 1'b0);
        run_read(1, 1, 32'h06,  32'h0,         1'b1);
        run_read(1, 1, 32'hFC,  32'hA500_00FC, 1'b0);
        run_read(1, 1, 32'h100, 32'h0,         1'b1);

        // Backpressure on rsp0 with req1 pending; req1 addr changes before accept.
        rsp0_ready[1] = 1'b0; rsp1_ready[1] = 1'b1;
        req0_valid[1] = 1'b1; req0_addr[1] = 32'h40;
        #1;
        chk("bp_accept0", 32'(req0_ready[1]), 32'd1);
        step();
        req0_valid[1] = 1'b0;
        req1_valid[1] = 1'b1; req1_addr[1] = 32'h30;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_r1_ready_busy", 32'(req1_ready[1]), 32'd0);
            step();
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 4) req1_addr[1] = 32'h24;
            #1;
            chk("bp_rsp0_valid", 32'(rsp0_valid[1]), 32'd1);
            chk("bp_rsp0_data", rsp0_data[1], 32'hA500_0040);
            chk("bp_r1_ready", 32'(req1_ready[1]), 32'd0);
            step();
        end
        rsp0_ready[1] = 1'b1;
        #1;
        chk("bp_rsp0_final", 32'(rsp0_valid[1]), 32'd1);
        chk("bp_r1_ready_last", 32'(req1_ready[1]), 32'd0);
        step();
        #1;
        chk("bp_rsp0_drop", 32'(rsp0_valid[1]), 32'd0);
        chk("bp_r1_ready_idle0", 32'(req1_ready[1]), 32'd0);
        step();
        #1;
        chk("bp_r1_accept", 32'(req1_ready[1]), 32'd1);
        step();
        req1_valid[1] = 1'b0;
        step();
        step();
        #1;
        chk("bp_rsp1_valid", 32'(rsp1_valid[1]), 32'd1);
        chk("bp_rsp1_data", rsp1_data[1], 32'hA500_0024);
        step();
        step();

        // Reset in the second WAIT cycle of the MEM_LAT=3 instance.
        rsp0_ready[3] = 1'b1;
        req0_valid[3] = 1'b1; req0_addr[3] = 32'h50;
        #1;
        chk("mw_accept", 32'(req0_ready[3]), 32'd1);
        step();
        req0_valid[3] = 1'b0;
        #1;
        chk("mw_issue_en", 32'(mem_en[3]), 32'd1);
        step();
        #1;
        chk("mw_wait1_en", 32'(mem_en[3]), 32'd1);
        step();
        rst = 1'b1;
        step();
        #1;
        chk("mw_mem_en", 32'(mem_en[3]), 32'd0);
        chk("mw_mem_addr", mem_addr[3], 32'd0);
        chk("mw_rsp0_valid", 32'(rsp0_valid[3]), 32'd0);
        chk("mw_rsp0_data", rsp0_data[3], 32'd0);
        chk("mw_rsp0_err", 32'(rsp0_err[3]), 32'd0);
        chk("mw_busy", 32'(busy[3]), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            chk("mw_no_rsp", 32'(rsp0_valid[3]), 32'd0);
        end
        step();
        run_read(3, 0, 32'h80, 32'hA500_0080, 1'b0);

        // Latency sweep: response exactly at A+2+MEM_LAT.
        run_read(1, 0, 32'h14, 32'hA500_0014, 1'b0);
        run_read(2, 1, 32'h18, 32'hA500_0018, 1'b0);
        run_read(3, 0, 32'h1C, 32'hA500_001C, 1'b0);
        run_read(4, 1, 32'h24, 32'hA500_0024, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the memory size in bytes.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the address width in bits.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, legal range 1..4, meaning the memory read latency in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester 0 (instruction fetch) / requester 1 (data load) has a read pending.
REQ-007 The block SHALL have ports req0_addr / req1_addr, input, ADDR_WIDTH bits each: byte address of the requested 32-bit word.
REQ-008 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: request accepted this cycle.
REQ-009 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1 bit each: response held for that requester.
REQ-010 The block SHALL have ports rsp0_ready / rsp1_ready, input, 1 bit each: requester consumes the response.
REQ-011 The block SHALL have ports rsp0_data / rsp1_data, output, 32 bits each: read word.
REQ-012 The block SHALL have ports rsp0_err / rsp1_err, output, 1 bit each: the request was rejected.
REQ-013 The block SHALL have port mem_en, output, 1 bit: read enable to the word-read memory.
REQ-014 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: memory byte address.
REQ-015 The block SHALL have port mem_rdata, input, 32 bits: memory read data, valid MEM_LAT cycles after the first mem_en cycle.
REQ-016 The block SHALL have port busy, output, 1 bit: state != IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with exactly one transaction outstanding.
REQ-018 In IDLE, reqN_ready SHALL be asserted combinationally to the granted requester only, and only when its valid is high; in all other states both readies SHALL be 0.
REQ-019 Arbitration SHALL be round-robin using a last-grant register:
- single valid: that requester wins;
- both valid: the requester not last granted wins;
- last-grant updates on every accept, error accepts included.
REQ-020 On accept in cycle A, the block SHALL latch the address and requester id.
- Legal address: next state ISSUE.
- Illegal address (addr[1:0] != 0, or addr > MEM_DEPTH-4): next state RESP with err=1, data=0, and no mem_en at any point.
REQ-021 ISSUE (cycle A+1) SHALL last 1 cycle and assert mem_en=1 with mem_addr equal to the latched address; next state WAIT.
REQ-022 WAIT SHALL last exactly MEM_LAT cycles, keeping mem_en=1 and mem_addr stable, using a down-counter.
- At the end of the final WAIT cycle, mem_rdata is captured into the response register.
- Next state RESP, entered at cycle A+2+MEM_LAT.
REQ-023 In RESP, rspN_valid SHALL be 1 for the latched requester only; data and err are held stable until rspN_ready=1.
- On the rspN_ready=1 cycle: next state IDLE, rsp valid drops the following cycle.
- A new accept is possible no earlier than the cycle after the return to IDLE.
REQ-024 mem_en SHALL be 0 in IDLE and RESP, and mem_addr SHALL hold its last value.
REQ-025 Requests arriving in non-IDLE states SHALL remain pending (not dropped); requesters hold valid and addr until ready.
REQ-026 A change of reqN_addr while the request is not accepted SHALL have no effect, since the address is sampled only at accept.
REQ-027 Minimum accepted-to-accepted spacing SHALL be MEM_LAT+4 cycles for legal reads (with rsp_ready tied high) and 3 cycles for errors.

Reset
REQ-028 When rst=1 at a clock edge, all state SHALL reset regardless of FSM state, including mid-ISSUE, mid-WAIT and mid-RESP.
- FSM to IDLE; any in-flight transaction discarded.
- All outputs 0 the next cycle: mem_en, mem_addr, rsp*_valid, rsp*_data, rsp*_err, busy.
- WAIT counter 0; last-grant = 1, so requester 0 wins the first contention.
REQ-029 During rst=1, req*_ready SHALL be 0.

Verification
REQ-030 Bench memory model: mem_rdata = 0xA5000000 | mem_addr, delayed MEM_LAT cycles from mem_en.
REQ-031 Single read: req0_valid=1, addr=0x10, rsp0_ready=1, MEM_LAT=1.
- Required: ready at cycle A; mem_en at A+1..A+2; rsp0_valid at A+3; rsp0_data=0xA5000010, err=0.
REQ-032 Contention after reset: req0 and req1 valid together, addrs 0x04 and 0x08.
- Required grant order: req0, req1, req0.
- Each response routed only to its own rsp port with the matching data.
REQ-033 Illegal addresses: req1 addr=0x06, then addr=0xFC, then addr=0x100 (MEM_DEPTH=256).
- 0x06: rsp1_err=1, data=0, mem_en never asserted.
- 0xFC: legal, data=0xA50000FC.
- 0x100: err=1.
REQ-034 Backpressure: rsp0_ready=0 for 5 cycles in RESP while req1_valid=1.
- Required: rsp0 data stable; req1_ready=0 throughout.
- req1 accepted in the cycle after return to IDLE.
REQ-035 Reset mid-WAIT with MEM_LAT=3: assert rst in the second WAIT cycle.
- Required: next cycle all outputs 0 and busy=0; no rsp emitted for the aborted read.
- A new req0 then completes normally.
REQ-036 MEM_LAT sweep 1..4: rsp valid SHALL first appear at A+2+MEM_LAT with correct data.
